// File: rtl/tdm_burst_sequencer.sv
// tdm_burst_sequencer
//
// Frame-synchronous scheduler for the TDM stream interface. On every frame
// sync (falling edge of f0_n) each of NCH channels plays out a gated bit-clock
// burst: an enable envelope, count 50%-duty pulses starting at a programmable
// half-tick offset, and an optional single tail pulse after the envelope.
// One clk cycle is one half-bit tick of the c4 clock.
//
// Ports:
//   clk        c4-domain clock, one cycle = one half-tick
//   rst        synchronous active-high reset
//   f0_n       frame sync, active low, synchronous to clk
//   cfg_we     config write strobe (writes the shadow bank of cfg_sel)
//   cfg_sel    channel select for the write
//   cfg_en     channel enable
//   cfg_tail   emit a tail pulse one half-tick after the envelope closes
//   cfg_offset first-pulse offset in half-ticks
//   cfg_count  number of clock pulses
//   clk_en     per-channel enable envelope (registered)
//   clk_out    per-channel gated bit clock (registered)
//   busy       a frame is being played out
//   slip       one-cycle pulse when a frame sync arrives before the frame ended
//   slip_cnt   saturating count of slips
module tdm_burst_sequencer #(
    parameter int NCH      = 4,
    parameter int FRAME_HT = 512,
    parameter int HTW      = 9,
    parameter int CNTW     = 8,
    localparam int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f0_n,
    input  logic            cfg_we,
    input  logic [SELW-1:0] cfg_sel,
    input  logic            cfg_en,
    input  logic            cfg_tail,
    input  logic [HTW-1:0]  cfg_offset,
    input  logic [CNTW-1:0] cfg_count,
    output logic [NCH-1:0]  clk_en,
    output logic [NCH-1:0]  clk_out,
    output logic            busy,
    output logic            slip,
    output logic [7:0]      slip_cnt
);

    // One extra bit so offset + 2*count and its tail position never wrap.
    localparam int EW = HTW + 1;
    localparam logic [HTW-1:0] LAST_HT = HTW'(FRAME_HT - 1);

    typedef struct packed {
        logic            en;
        logic            tail;
        logic [HTW-1:0]  offset;
        logic [CNTW-1:0] count;
    } chan_cfg_t;

    typedef enum logic {ARMED, RUN} state_t;

    state_t          state_reg, state_next;
    logic [HTW-1:0]  t_reg, t_next;
    logic            f0_q;
    logic            frame_start;
    logic            slip_next;
    logic            run_next;
    logic [NCH-1:0]  clk_en_next, clk_out_next;
    chan_cfg_t       cfg_new;
    chan_cfg_t       shadow_reg [NCH];
    chan_cfg_t       active_reg [NCH];
    chan_cfg_t       active_next [NCH];

    assign frame_start = f0_q & ~f0_n;
    assign cfg_new     = '{en: cfg_en, tail: cfg_tail, offset: cfg_offset, count: cfg_count};

    // Frame timing FSM. A sync during the last half-tick is a seamless
    // back-to-back frame; any earlier sync while running is a slip.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        slip_next  = 1'b0;
        case (state_reg)
            ARMED: begin
                if (frame_start) begin
                    state_next = RUN;
                    t_next     = '0;
                end
            end
            RUN: begin
                if (frame_start) begin
                    t_next    = '0;
                    slip_next = (t_reg != LAST_HT);
                end else if (t_reg == LAST_HT) begin
                    state_next = ARMED;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            default: begin
                state_next = ARMED;
                t_next     = '0;
            end
        endcase
    end

    assign run_next = (state_next == RUN);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic           write_hit;
            logic           live;
            logic           pulse_hit;
            logic           tail_hit;
            logic [EW-1:0]  t_ext, off_ext, end_ht;

            assign write_hit = cfg_we && (cfg_sel == SELW'(gi));

            always_ff @(posedge clk) begin
                if (rst)
                    shadow_reg[gi] <= '0;
                else if (write_hit)
                    shadow_reg[gi] <= cfg_new;
            end

            // Active bank only moves at a frame start; a write landing in the
            // same cycle goes straight through so it applies to that frame.
            always_comb begin
                active_next[gi] = active_reg[gi];
                if (frame_start)
                    active_next[gi] = write_hit ? cfg_new : shadow_reg[gi];
            end

            always_ff @(posedge clk) begin
                if (rst)
                    active_reg[gi] <= '0;
                else
                    active_reg[gi] <= active_next[gi];
            end

            // Outputs are evaluated against the upcoming half-tick so that the
            // registered ports line up with frame cycle t.
            assign t_ext   = {1'b0, t_next};
            assign off_ext = {1'b0, active_next[gi].offset};
            assign end_ht  = off_ext + (EW'(active_next[gi].count) << 1);
            assign live    = run_next && active_next[gi].en && (active_next[gi].count != '0);

            // t >= offset here, so the parity of (t - offset) is t[0] ^ offset[0].
            assign pulse_hit = (t_ext >= off_ext) && (t_ext < end_ht) &&
                               (t_ext[0] == off_ext[0]);
            assign tail_hit  = active_next[gi].tail && (t_ext == end_ht + 1'b1);

            assign clk_en_next[gi]  = live && (t_ext <= end_ht);
            assign clk_out_next[gi] = live && (pulse_hit || tail_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARMED;
            t_reg     <= '0;
            f0_q      <= 1'b1;
            busy      <= 1'b0;
            slip      <= 1'b0;
            slip_cnt  <= '0;
            clk_en    <= '0;
            clk_out   <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            f0_q      <= f0_n;
            busy      <= run_next;
            slip      <= slip_next;
            if (slip_next && (slip_cnt != 8'hFF))
                slip_cnt <= slip_cnt + 8'd1;
            clk_en    <= clk_en_next;
            clk_out   <= clk_out_next;
        end
    end

endmodule

// File: tb/tb_tdm_burst_sequencer.sv
// Testbench for tdm_burst_sequencer: directed steps, a behavioural frame model
// pushes the expected port values each cycle and they are compared one cycle
// later when the DUT presents its registered outputs.
module tb_tdm_burst_sequencer;

    localparam int NCH      = 4;
    localparam int FRAME_HT = 512;
    localparam int HTW      = 9;
    localparam int CNTW     = 8;

    logic            clk;
    logic            rst;
    logic            f0_n;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic            cfg_en;
    logic            cfg_tail;
    logic [HTW-1:0]  cfg_offset;
    logic [CNTW-1:0] cfg_count;
    logic [NCH-1:0]  clk_en;
    logic [NCH-1:0]  clk_out;
    logic            busy;
    logic            slip;
    logic [7:0]      slip_cnt;

    tdm_burst_sequencer #(
        .NCH(NCH), .FRAME_HT(FRAME_HT), .HTW(HTW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .f0_n(f0_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_en(cfg_en), .cfg_tail(cfg_tail),
        .cfg_offset(cfg_offset), .cfg_count(cfg_count),
        .clk_en(clk_en), .clk_out(clk_out), .busy(busy), .slip(slip), .slip_cnt(slip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] out;
        logic           busy;
        logic           slip;
        logic [7:0]     slip_cnt;
    } exp_t;

    typedef struct {
        bit en;
        bit tail;
        int off;
        int cnt;
    } mcfg_t;

    exp_t  sb[$];
    mcfg_t m_sh[NCH];
    mcfg_t m_act[NCH];
    bit    m_run;
    bit    m_f0q;
    int    m_t;
    int    m_slipcnt;
    bit    m_slip;
    int    n_checks;
    int    n_fail;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (model t=%0d run=%0d)", tag, obs, exp, m_t, m_run);
        end
    endtask

    function automatic bit model_en(int ch);
        if (!m_run || !m_act[ch].en || m_act[ch].cnt == 0) return 1'b0;
        return (m_t <= m_act[ch].off + 2 * m_act[ch].cnt);
    endfunction

    function automatic bit model_out(int ch);
        if (!m_run || !m_act[ch].en || m_act[ch].cnt == 0) return 1'b0;
        for (int k = 0; k < m_act[ch].cnt; k++)
            if (m_t == m_act[ch].off + 2 * k) return 1'b1;
        return m_act[ch].tail && (m_t == m_act[ch].off + 2 * m_act[ch].cnt + 1);
    endfunction

    // Advance the model with the inputs currently driven, push the expected
    // outputs, clock once, then pop and compare against the DUT.
    task automatic tick();
        exp_t e;
        bit   fs;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_sh[i]  = '{1'b0, 1'b0, 0, 0};
                m_act[i] = '{1'b0, 1'b0, 0, 0};
            end
            m_run = 0; m_t = 0; m_slipcnt = 0; m_slip = 0; m_f0q = 1;
        end else begin
            fs = m_f0q && !f0_n;
            if (cfg_we)
                m_sh[cfg_sel] = '{cfg_en, cfg_tail, int'(cfg_offset), int'(cfg_count)};
            m_slip = 0;
            if (fs) begin
                for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
                if (m_run && m_t < FRAME_HT - 1) begin
                    m_slip = 1;
                    if (m_slipcnt < 255) m_slipcnt++;
                end
                m_run = 1;
                m_t   = 0;
            end else if (m_run) begin
                if (m_t == FRAME_HT - 1) begin
                    m_run = 0;
                    m_t   = 0;
                end else begin
                    m_t++;
                end
            end
            m_f0q = f0_n;
        end
        for (int i = 0; i < NCH; i++) begin
            e.en[i]  = model_en(i);
            e.out[i] = model_out(i);
        end
        e.busy     = m_run;
        e.slip     = m_slip;
        e.slip_cnt = 8'(m_slipcnt);
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("clk_en",   32'(clk_en),   32'(e.en));
        check("clk_out",  32'(clk_out),  32'(e.out));
        check("busy",     32'(busy),     32'(e.busy));
        check("slip",     32'(slip),     32'(e.slip));
        check("slip_cnt", 32'(slip_cnt), 32'(e.slip_cnt));
        cfg_we = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(int sel, bit en, bit tail, int off, int cnt);
        cfg_we     = 1'b1;
        cfg_sel    = 2'(sel);
        cfg_en     = en;
        cfg_tail   = tail;
        cfg_offset = HTW'(off);
        cfg_count  = CNTW'(cnt);
    endtask

    task automatic frame_pulse();
        f0_n = 1'b0;
        tick();
        f0_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_run = 0; m_t = 0; m_slipcnt = 0; m_slip = 0; m_f0q = 1;
        rst = 1'b1; f0_n = 1'b1; cfg_we = 1'b0; cfg_sel = '0;
        cfg_en = 1'b0; cfg_tail = 1'b0; cfg_offset = '0; cfg_count = '0;

        // Reset state
        run(3);
        rst = 1'b0;
        tick();

        // Four channels: aligned, odd offset with tail, and two overlapping
        set_cfg(0, 1, 0, 0, 32); tick();
        set_cfg(1, 1, 1, 3, 31); tick();
        set_cfg(2, 1, 0, 2, 32); tick();
        set_cfg(3, 1, 1, 2, 31); tick();

        // Single frame, then idle back to ARMED
        frame_pulse();
        run(530);

        // Mid-frame write must not disturb the running frame
        frame_pulse();           // now at t=0
        run(20);                 // now at t=20
        set_cfg(0, 1, 0, 0, 4);
        tick();                  // t=21
        run(490);                // t=511
        frame_pulse();           // back-to-back, no slip; ch0 now 4 pulses

        // Early sync at t=100 with a write in the frame-start cycle
        run(100);
        set_cfg(1, 1, 0, 5, 2);
        frame_pulse();
        run(80);

        // Repeated early syncs drive slip_cnt into saturation
        for (int i = 0; i < 300; i++) begin
            f0_n = 1'b0;
            tick();
            f0_n = 1'b1;
            tick();
        end

        // Reset mid-frame at t=30, then a frame with cleared configs
        run(29);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        frame_pulse();
        run(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
